// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a one-entry output register.
// Grant search starts at the priority pointer and wraps; the pointer advances past each winner.
module rr_arb_mux #(
    parameter int unsigned ELEM_WIDTH = 8,
    parameter int unsigned NUM_ELEM   = 6
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic [NUM_ELEM-1:0]            i_valid_i,
    input  logic [NUM_ELEM*ELEM_WIDTH-1:0] i_data_i,
    output logic [NUM_ELEM-1:0]            i_ready_o,
    output logic                           o_valid_o,
    output logic [ELEM_WIDTH-1:0]          o_data_o,
    output logic [$clog2(NUM_ELEM)-1:0]    o_sel_o,
    input  logic                           o_ready_i
);

    localparam int unsigned SelW = $clog2(NUM_ELEM);
    typedef logic [SelW-1:0] sel_t;

    sel_t                  ptr_q, ptr_d;
    logic                  valid_q, valid_d;
    logic [ELEM_WIDTH-1:0] data_q, data_d;
    sel_t                  sel_q, sel_d;

    sel_t                  cand;
    sel_t                  grant_idx;
    logic                  grant_found;
    logic [ELEM_WIDTH-1:0] grant_data;
    logic                  can_accept;
    logic                  transfer;

    // Scan ptr, ptr+1, ... modulo NUM_ELEM; first valid requester wins.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            if (32'(ptr_q) + i >= NUM_ELEM) begin
                cand = sel_t'(32'(ptr_q) + i - NUM_ELEM);
            end else begin
                cand = sel_t'(32'(ptr_q) + i);
            end
            if (!grant_found && i_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            if (sel_t'(i) == grant_idx) begin
                grant_data = i_data_i[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    assign can_accept = !valid_q || o_ready_i;

    // Ready is a function of valid, pointer and output state only; data never feeds it.
    always_comb begin
        i_ready_o = '0;
        if (grant_found && can_accept && !arst_i) begin
            i_ready_o = NUM_ELEM'(1) << grant_idx;
        end
    end

    assign transfer = |i_ready_o;

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (transfer) begin
            valid_d = 1'b1;
            data_d  = grant_data;
            sel_d   = grant_idx;
            ptr_d   = (grant_idx == sel_t'(NUM_ELEM - 1)) ? '0 : grant_idx + 1'b1;
        end else if (o_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign o_valid_o = valid_q;
    assign o_data_o  = data_q;
    assign o_sel_o   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (6 requesters, 8-bit data): directed scenarios plus a
// randomized run against a modulo-search reference model and an in-order scoreboard.
module tb_rr_arb_mux;

    localparam int N = 6;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           arst;
    logic [N-1:0]   i_valid;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_ready;
    logic           o_valid;
    logic [W-1:0]   o_data;
    logic [2:0]     o_sel;
    logic           o_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_os;

    rr_arb_mux #(.ELEM_WIDTH(W), .NUM_ELEM(N)) dut (
        .clk_i    (clk),
        .arst_i   (arst),
        .i_valid_i(i_valid),
        .i_data_i (i_data),
        .i_ready_o(i_ready),
        .o_valid_o(o_valid),
        .o_data_o (o_data),
        .o_sel_o  (o_sel),
        .o_ready_i(o_ready)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        for (int i = 0; i < N; i++) begin
            if (i_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g >= 0 && (!m_ov || o_ready)) return N'(1) << g;
        return '0;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        o_ready = r;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic step();
        int g;
        logic xfer;
        g    = exp_grant();
        xfer = (g >= 0) && (!m_ov || o_ready);
        @(posedge clk);
        if (xfer) begin
            m_ov  = 1'b1;
            m_od  = i_data[g*W +: W];
            m_os  = g;
            m_ptr = (g + 1) % N;
        end else if (o_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #2;
        arst  = 1'b0;
        m_ptr = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_os  = 0;
    endtask

    function automatic logic [N*W-1:0] ramp_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 'h10);
        return d;
    endfunction

    task automatic test_reset();
        drive('1, ramp_data(), 1'b1);
        arst = 1'b1;
        #1;
        total += 4;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", o_data); end
        if (o_sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", o_sel); end
        if (i_ready !== 6'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", i_ready); end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_single();
        logic [N*W-1:0] d;
        do_reset();
        d = '0;
        d[2*W +: W] = 8'hA5;
        drive(6'b000100, d, 1'b1);
        total++;
        if (i_ready !== 6'b000100) begin
            bad++; $display("FAIL single_ready got=%b exp=000100", i_ready);
        end
        step();
        drive('0, '0, 1'b0);
        total += 3;
        if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", o_valid); end
        if (o_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", o_data); end
        if (o_sel !== 3'd2) begin bad++; $display("FAIL single_sel got=%0d exp=2", o_sel); end
        // Pointer now at 3: with everything valid the next grant must be 3.
        drive('1, ramp_data(), 1'b1);
        total++;
        if (i_ready !== 6'b001000) begin
            bad++; $display("FAIL single_ptr got=%b exp=001000", i_ready);
        end
        step();
    endtask

    task automatic test_round_robin();
        int seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        do_reset();
        drive('1, ramp_data(), 1'b1);
        for (int c = 0; c < 8; c++) begin
            step();
            total += 3;
            if (o_valid !== 1'b1) begin
                bad++; $display("FAIL rr_valid[%0d] got=%b exp=1", c, o_valid);
            end
            if (o_sel !== 3'(seq[c])) begin
                bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", c, o_sel, seq[c]);
            end
            if (o_data !== 8'(seq[c] + 'h10)) begin
                bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", c, o_data, 8'(seq[c] + 'h10));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive('1, ramp_data(), 1'b1);
        step();
        step();
        drive('1, ramp_data(), 1'b0);
        for (int c = 0; c < 4; c++) begin
            total += 4;
            if (i_ready !== 6'b0) begin
                bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, i_ready);
            end
            if (o_valid !== 1'b1) begin
                bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, o_valid);
            end
            if (o_sel !== 3'd1) begin bad++; $display("FAIL bp_sel[%0d] got=%0d exp=1", c, o_sel); end
            if (o_data !== 8'h11) begin
                bad++; $display("FAIL bp_data[%0d] got=%h exp=11", c, o_data);
            end
            step();
        end
        drive('1, ramp_data(), 1'b1);
        total++;
        if (i_ready !== 6'b000100) begin
            bad++; $display("FAIL bp_release_ready got=%b exp=000100", i_ready);
        end
        step();
        total++;
        if (o_sel !== 3'd2) begin bad++; $display("FAIL bp_release_sel got=%0d exp=2", o_sel); end
    endtask

    task automatic test_pointer_skip();
        do_reset();
        drive(6'b001000, ramp_data(), 1'b1);
        step();
        drive(6'b000011, ramp_data(), 1'b1);
        total++;
        if (i_ready !== 6'b000001) begin
            bad++; $display("FAIL skip_wrap_ready got=%b exp=000001", i_ready);
        end
        step();
        total++;
        if (o_sel !== 3'd0) begin bad++; $display("FAIL skip_wrap_sel got=%0d exp=0", o_sel); end
        total++;
        if (i_ready !== 6'b000010) begin
            bad++; $display("FAIL skip_next_ready got=%b exp=000010", i_ready);
        end
        step();
        total++;
        if (o_sel !== 3'd1) begin bad++; $display("FAIL skip_next_sel got=%0d exp=1", o_sel); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        drive(6'b001000, ramp_data(), 1'b1);
        step();
        drive('0, '0, 1'b0);
        total += 2;
        if (o_valid !== 1'b1 || o_sel !== 3'd3) begin
            bad++; $display("FAIL mid_pre got=%b/%0d exp=1/3", o_valid, o_sel);
        end
        #2;
        arst = 1'b1;
        #1;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_sel !== 3'd0) begin
            bad++; $display("FAIL mid_reset got=%b/%h/%0d exp=0/00/0", o_valid, o_data, o_sel);
        end
        arst  = 1'b0;
        m_ptr = 0;
        m_ov  = 1'b0;
        @(posedge clk);
        #1;
        drive('1, ramp_data(), 1'b1);
        step();
        total++;
        if (o_valid !== 1'b1 || o_sel !== 3'd0) begin
            bad++; $display("FAIL mid_first got=%b/%0d exp=1/0", o_valid, o_sel);
        end
    endtask

    task automatic test_random();
        logic [W+2:0] sb [$];
        logic [W+2:0] exp_e;
        int           waits [N];
        int           accepted = 0;
        int           drained  = 0;
        logic         stalled;
        logic [W-1:0] hold_d;
        logic [2:0]   hold_s;
        int           g;
        do_reset();
        for (int k = 0; k < N; k++) waits[k] = 0;
        for (int c = 0; c < 10002; c++) begin
            if (c < 10000) begin
                drive(N'($urandom), {$urandom, $urandom}, ($urandom_range(3) != 0));
            end else begin
                drive('0, '0, 1'b1);
            end
            total++;
            if (i_ready !== exp_ready()) begin
                bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, i_ready, exp_ready());
            end
            if (o_valid && o_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rnd_extra[%0d] got=%0d/%h exp=none", c, o_sel, o_data);
                end else begin
                    exp_e = sb.pop_front();
                    drained++;
                    if ({o_sel, o_data} !== exp_e) begin
                        bad++;
                        $display("FAIL rnd_order[%0d] got=%0d/%h exp=%0d/%h", c, o_sel, o_data,
                                 exp_e[W+2:W], exp_e[W-1:0]);
                    end
                end
            end
            g = -1;
            for (int k = 0; k < N; k++) if (i_ready[k] && i_valid[k]) g = k;
            if (g >= 0) begin
                sb.push_back({3'(g), i_data[g*W +: W]});
                accepted++;
                for (int k = 0; k < N; k++) begin
                    if (k == g) waits[k] = 0;
                    else if (i_valid[k]) waits[k]++;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!i_valid[k]) waits[k] = 0;
                if (waits[k] > N - 1) begin
                    total++; bad++;
                    $display("FAIL rnd_fair[%0d] req=%0d got=%0d exp<=%0d", c, k, waits[k], N - 1);
                    waits[k] = 0;
                end
            end
            stalled = o_valid && !o_ready;
            hold_d  = o_data;
            hold_s  = o_sel;
            step();
            if (stalled) begin
                total++;
                if (!o_valid || o_data !== hold_d || o_sel !== hold_s) begin
                    bad++;
                    $display("FAIL rnd_stall[%0d] got=%b/%h/%0d exp=1/%h/%0d", c, o_valid, o_data,
                             o_sel, hold_d, hold_s);
                end
            end
            total++;
            if (o_valid !== m_ov || (m_ov && (o_data !== m_od || o_sel !== 3'(m_os)))) begin
                bad++;
                $display("FAIL rnd_out[%0d] got=%b/%h/%0d exp=%b/%h/%0d", c, o_valid, o_data, o_sel,
                         m_ov, m_od, m_os);
            end
        end
        total++;
        if (drained != accepted || sb.size() != 0) begin
            bad++; $display("FAIL rnd_count got=%0d exp=%0d", drained, accepted);
        end
    endtask

    initial begin
        arst    = 1'b1;
        i_valid = '0;
        i_data  = '0;
        o_ready = 1'b0;
        m_ptr   = 0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_os    = 0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
